// File: rtl/blk_ram_stream_reader_pkg.sv
// blk_ram_stream_reader_pkg: shared state encoding and sizing defaults for the RAM stream reader
package blk_ram_stream_reader_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int SKID_DEPTH      = 2;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 9;

endpackage

// File: rtl/blk_ram_skid2.sv
// blk_ram_skid2: 2-entry FIFO holding RAM words plus their last marker; entry 0 is the head
module blk_ram_skid2
    import blk_ram_stream_reader_pkg::*;
#(
    parameter int W = DEF_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [W-1:0] d0, d1;
    logic         l0, l1;
    logic [1:0]   widx;

    assign widx      = count - {1'b0, pop};
    assign head_data = d0;
    assign head_last = l0;

    // Shift on pop, write the incoming word into the slot left free after the pop
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            d0    <= '0;
            d1    <= '0;
            l0    <= 1'b0;
            l1    <= 1'b0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && count == 2'(SKID_DEPTH)) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (push && widx == 2'd0) begin
                d0 <= push_data;
                l0 <= push_last;
            end
            if (push && widx != 2'd0) begin
                d1 <= push_data;
                l1 <= push_last;
            end
        end
    end

endmodule

// File: rtl/blk_ram_stream_reader.sv
// blk_ram_stream_reader: reads a contiguous RAM region via port B and streams it out valid/ready
// Optional abort input enabled by defining BLK_RAM_STREAM_READER_ABORT_EN.
module blk_ram_stream_reader
    import blk_ram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef BLK_RAM_STREAM_READER_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] rd_addr, issue_left;
    logic                  inflight, inflight_last;
    logic                  pop, fin, abort_hit, head_last;
    logic [1:0]            count;
    logic [2:0]            occ;

`ifdef BLK_RAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort & busy;
`else
    assign abort_hit = 1'b0;
`endif

    assign busy     = state != IDLE;
    assign ram_addr = rd_addr;
    assign m_valid  = count != 2'd0;
    assign m_last   = m_valid & head_last;
    assign pop      = m_valid & m_ready;
    assign fin      = pop & head_last;
    assign occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

    // Issue a read only when the skid buffer can hold it once it returns; sequence the command
    always_comb begin
        ram_en   = (state == RUN) && (occ < 3'(SKID_DEPTH));
        state_nx = abort_hit        ? IDLE :
                   state == IDLE    ? (start ? RUN : IDLE) :
                   state == RUN     ? ((ram_en && issue_left == '0) ? DRAIN : RUN) :
                                      (fin ? IDLE : DRAIN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Address/issue counters, read-latency tracking and the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr       <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= fin | abort_hit;
            inflight      <= ram_en;
            inflight_last <= ram_en && issue_left == '0;
            if (state == IDLE && start) begin
                rd_addr    <= base_addr;
                issue_left <= len_m1;
            end else if (ram_en) begin
                rd_addr    <= rd_addr + 1'b1;
                issue_left <= issue_left - 1'b1;
            end
        end
    end

    // Reads returning after an abort find the reader idle and are dropped
    blk_ram_skid2 #(.W(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_hit),
        .push      (inflight & busy),
        .push_data (ram_dout),
        .push_last (inflight_last),
        .pop       (pop),
        .count     (count),
        .head_data (m_data),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_blk_ram_stream_reader.sv
// tb_blk_ram_stream_reader: directed self-checking bench with a behavioural RAM holding RAM[i]=i[8:0]
module tb_blk_ram_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] len_m1 = '0;
    logic        busy, done, ram_en, m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [11:0] ram_addr;
    logic [8:0]  ram_dout = '0;
    logic [8:0]  m_data;
`ifdef BLK_RAM_STREAM_READER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic [8:0]  mem [4096];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    blk_ram_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len_m1    (len_m1),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
`ifdef BLK_RAM_STREAM_READER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial for (int i = 0; i < 4096; i++) mem[i] = 9'(i);

    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start in the current cycle and follows the command until done; returns inside the done cycle
    task automatic run(input logic [11:0] base, input logic [11:0] len, input int mode, input bit poke);
        int got = 0, issued = 0;
        bit seen_done = 0, prev_stall = 0, prev_fin = 0;
        logic [8:0] pd = '0;
        logic pl = 1'b0;
        start = 1'b1;
        base_addr = base;
        len_m1 = len;
        for (int k = 1; k <= 5000 && !seen_done; k++) begin
            @(negedge clk);
            start = poke && (k == 1 || k == 2);
            base_addr = start ? base + 12'h123 : base;
            m_ready = (mode == 0) ? 1'b1 : (k % 4 == 0 || k % 4 == 3);
            #1;
            chk("occupancy", 32'(issued - got <= 2), 1);
            if (done) begin
                chk("done_after_last", 32'(prev_fin), 1);
                chk("done_words", got, 32'(len) + 1);
                chk("done_busy", busy, 0);
                if (mode == 0) chk("done_latency", k, 32'(len) + 4);
                seen_done = 1;
            end else begin
                chk("busy", busy, 1);
            end
            if (mode == 0 && k == 1) chk("ram_en_latency", ram_en, 1);
            if (mode == 0 && k < 3) chk("early_valid", m_valid, 0);
            if (mode == 0 && k == 3) chk("valid_latency", m_valid, 1);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pd);
                chk("stall_last", m_last, pl);
            end
            if (ram_en) begin
                chk("ram_addr", ram_addr, (32'(base) + issued) & 32'hFFF);
                issued++;
            end
            prev_fin = 0;
            if (m_valid && m_ready) begin
                chk("data", m_data, (32'(base) + got) & 32'h1FF);
                chk("last", m_last, 32'(got == 32'(len)));
                prev_fin = (got == 32'(len));
                got++;
            end
            prev_stall = m_valid & ~m_ready;
            pd = m_data;
            pl = m_last;
        end
        chk("seen_done", 32'(seen_done), 1);
        chk("issued", issued, 32'(len) + 1);
    endtask

    initial begin
        int got;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_data", m_data, 0);
        reset = 1'b0;
        @(negedge clk);
        run(12'h010, 12'd3, 0, 0);
        run(12'hFFE, 12'd3, 0, 0);
        run(12'h040, 12'd15, 1, 0);
        run(12'h0AB, 12'd0, 0, 1);
        run(12'h0C0, 12'd0, 0, 0);
        run(12'h005, 12'd4095, 0, 0);
        @(negedge clk);
        start = 1'b1;
        base_addr = 12'h100;
        len_m1 = 12'd9;
        m_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && got < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) got++;
        end
        chk("reset_reached_word5", got, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_ram_en", ram_en, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        #1;
        chk("midrst_done_later", done, 0);
        chk("midrst_valid_later", m_valid, 0);
        run(12'h200, 12'd2, 0, 0);
`ifdef BLK_RAM_STREAM_READER_ABORT_EN
        @(negedge clk);
        start = 1'b1;
        base_addr = 12'h300;
        len_m1 = 12'd7;
        got = 0;
        for (int k = 0; k < 50 && got < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid && m_ready) got++;
        end
        chk("abort_reached_word3", got, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 1);
        chk("abort_ram_en", ram_en, 0);
        @(negedge clk);
        #1;
        chk("abort_done_once", done, 0);
        chk("abort_valid_later", m_valid, 0);
        run(12'h020, 12'd3, 0, 0);
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blk_ram_stream_reader.md
Name: blk_ram_stream_reader

Overview:
- Read-side companion to the simple dual-port 4k x 9 block RAM, which has no output register and one-cycle read latency.
- On a command, reads a contiguous region through RAM port B and presents the words as a valid/ready stream with a last marker.
- Absorbs the RAM read latency and downstream backpressure with a 2-entry skid buffer. Sustains 1 word/cycle when the sink is always ready.

Parameters:
- ADDR_WIDTH, 12, RAM address width; the region wraps modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 9, RAM word width.

Ports:
- clk  in  1  Single clock for all logic. Also drives RAM clkb.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  One-cycle command strobe. Ignored while busy=1.
- base_addr  in  ADDR_WIDTH  First address to read. Sampled with start.
- len_m1  in  ADDR_WIDTH  Word count minus 1, giving 1..4096 words. Sampled with start.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse when the final word is accepted by the sink.
- ram_en  out  1  To RAM enb. One read is issued per cycle ram_en=1.
- ram_addr  out  ADDR_WIDTH  To RAM addrb.
- ram_dout  in  DATA_WIDTH  From RAM doutb. Valid the cycle after ram_en.
- m_data  out  DATA_WIDTH  Stream data.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready. A transfer occurs when m_valid & m_ready.
- m_last  out  1  High with the final word of the command.

Behaviour:
- Reset values: busy, done, ram_en, m_valid and m_last are 0. ram_addr, m_data and all counters are 0. The skid buffer is empty and the state is IDLE.
- Reset asserted mid-command discards in-flight reads and buffered words. No done pulse is produced.
- State IDLE -> RUN:
  - start=1 latches base_addr into rd_addr, len_m1 into issue_left, and len_m1 into xfer_left.
  - busy rises the next cycle.
- State RUN (issuing reads):
  - ram_en = (issue_left not exhausted) & ((fifo_count + inflight - pop) < 2).
  - pop = m_valid & m_ready.
  - inflight = ram_en registered one cycle.
  - Each issue: rd_addr increments and wraps 4095 -> 0; issue_left decrements.
  - After the final issue, the state moves to DRAIN.
- State DRAIN: no further reads. Waits for the final word to transfer.
- Capture: when inflight=1, ram_dout is written into the skid buffer in the same cycle.
- Skid buffer:
  - Head entry drives m_data. m_valid = (fifo_count != 0).
  - m_last is high when the head entry is the final word (xfer_left == 0).
  - Data and m_last stay stable while m_valid & ~m_ready.
- Final transfer: the transfer of the word with m_last=1 triggers, in the next cycle:
  - done=1
  - busy=0
  - state returns to IDLE.
- A new start is accepted in the cycle done=1. It is ignored in all other busy cycles.
- Latency, for start sampled in cycle S with m_ready=1:
  - ram_en=1 in cycle S+1.
  - m_valid=1 in cycle S+3.
  - Words then flow 1/cycle. For N words, done=1 in cycle S+N+3.
- Backpressure: the skid buffer never overflows. Reads stall when occupancy plus inflight would exceed 2.
- Boundary cases:
  - len_m1=0 produces a single word with m_last=1.
  - len_m1=4095 reads every address exactly once, wrapping from base_addr back to base_addr-1.

Optional Feature:
- Macro: BLK_RAM_STREAM_READER_ABORT_EN.
- Enabled: adds input port abort (1 bit). abort=1 while busy has this effect in the next cycle:
  - ram_en=0
  - skid buffer flushed
  - m_valid=0
  - state IDLE
  - busy=0
  - done pulses once.
  abort while idle is ignored.
- Disabled: no abort port. A command always runs to completion.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DRAIN)
  - localparams for skid depth (2) and ADDR_WIDTH/DATA_WIDTH defaults, shared with the RAM wrapper users.
- One sub-module, blk_ram_skid2: 2-entry FIFO with data+last fields, push/pop, count and head outputs. The address and issue control stays in the top level.

Test Plan:
- Preload RAM[i]=i[8:0]. start with base=0x010, len_m1=3, m_ready=1.
  -> ram_en in S+1..S+4; m_data 0x010..0x013 in S+3..S+6; m_last on 0x013; done at S+7.
- base=0xFFE, len_m1=3.
  -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in order; m_last on the 4th word.
- len_m1=15 with m_ready toggling 1,0,0,1 repeating.
  -> all 16 words delivered in order, none lost or duplicated; m_data stable during stalls; fifo_count never exceeds 2.
- len_m1=0.
  -> exactly one word with m_last=1; a second start during busy is ignored; start in the done cycle is accepted.
- Assert reset for 1 cycle mid-transfer at word 5 of 10.
  -> next cycle: busy=0, m_valid=0, ram_en=0, no done.
- ABORT_EN build: abort at word 3 of 8.
  -> next cycle: m_valid=0, busy=0, done=1; a following start runs normally.
